sbox_layer_serial_3share: RTL

//  Serial sequencer for the masked PRINCE S-box layer in the second-order, 3-share datapath.

---
 rtl/sbox_layer_serial_3share.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sbox_layer_serial_3share.sv
// Serial nibble sequencer for the 3-share masked PRINCE S-box layer.
// Streams one nibble per cycle into an external 1-cycle S-box stage and rebuilds the 3-share result.
module sbox_layer_serial_3share #(
    parameter int NIBBLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   st1_in,
    input  logic [4*NIBBLES-1:0]   st2_in,
    input  logic [4*NIBBLES-1:0]   st3_in,
    input  logic [7:0]             rnd_in,
    output logic                   rnd_req,
    output logic [3:0]             sb_in1,
    output logic [3:0]             sb_in2,
    output logic [3:0]             sb_in3,
    output logic [7:0]             sb_r,
    input  logic [3:0]             sb_out1,
    input  logic [3:0]             sb_out2,
    input  logic [3:0]             sb_out3,
    output logic [4*NIBBLES-1:0]   res1,
    output logic [4*NIBBLES-1:0]   res2,
    output logic [4*NIBBLES-1:0]   res3,
    output logic                   busy,
    output logic                   done
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;

    logic            w_accept;
    logic            w_last_feed;
    logic            w_capture;

    assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last_feed = (r_state == S_FEED) && (r_cnt == CW'(NIBBLES - 1));
    // The stage has one cycle of latency, so the first FEED cycle has nothing to capture yet.
    assign w_capture   = ((r_state == S_FEED) && (r_cnt != '0)) || (r_state == S_DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_FEED;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_FEED: begin
                    r_cnt  <= r_cnt + CW'(1);
                    r_busy <= 1'b1;
                    r_done <= 1'b0;
                    if (w_last_feed) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    logic [W-1:0] w_st_in  [3];
    logic [3:0]   w_sb_out [3];
    logic [W-1:0] r_shift  [3];
    logic [W-1:0] r_res    [3];

    assign w_st_in[0]  = st1_in;
    assign w_st_in[1]  = st2_in;
    assign w_st_in[2]  = st3_in;
    assign w_sb_out[0] = sb_out1;
    assign w_sb_out[1] = sb_out2;
    assign w_sb_out[2] = sb_out3;

    // Each share owns its own shift and result register; no logic ever mixes two shares.
    for (genvar gi = 0; gi < 3; gi++) begin : g_share
        always_ff @(posedge clk) begin
            if (rst) begin
                r_shift[gi] <= '0;
                r_res[gi]   <= '0;
            end else begin
                if (w_accept) begin
                    r_shift[gi] <= w_st_in[gi];
                end else if (r_state == S_FEED) begin
                    r_shift[gi] <= r_shift[gi] >> 4;
                end
                if (w_capture) begin
                    r_res[gi] <= {w_sb_out[gi], r_res[gi][W-1:4]};
                end
            end
        end
    end

    assign sb_in1  = (r_state == S_FEED) ? r_shift[0][3:0] : 4'h0;
    assign sb_in2  = (r_state == S_FEED) ? r_shift[1][3:0] : 4'h0;
    assign sb_in3  = (r_state == S_FEED) ? r_shift[2][3:0] : 4'h0;
    assign rnd_req = r_busy;
    assign sb_r    = r_busy ? rnd_in : 8'h00;
    assign busy    = r_busy;
    assign done    = r_done;
    assign res1    = r_res[0];
    assign res2    = r_res[1];
    assign res3    = r_res[2];

endmodule
